// File: rtl/alu_arbiter_if.sv
// Request, ALU drive/return and response bundle for alu_arbiter.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high,
// and the sender holds valid and payload stable until it sees ready.
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             r0_valid;
    logic             r0_ready;
    logic [31:0]      r0_a;
    logic [31:0]      r0_b;
    logic [2:0]       r0_funct3;
    logic [6:0]       r0_funct7;
    logic [6:0]       r0_opcode;
    logic [TAG_W-1:0] r0_tag;

    logic             r1_valid;
    logic             r1_ready;
    logic [31:0]      r1_a;
    logic [31:0]      r1_b;
    logic [2:0]       r1_funct3;
    logic [6:0]       r1_funct7;
    logic [6:0]       r1_opcode;
    logic [TAG_W-1:0] r1_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_funct3;
    logic [6:0]       alu_funct7;
    logic [6:0]       alu_opcode;
    logic [31:0]      alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_funct3, r0_funct7, r0_opcode, r0_tag,
        input  r1_valid, r1_a, r1_b, r1_funct3, r1_funct7, r1_opcode, r1_tag,
        input  alu_out, rsp_ready,
        output r0_ready, r1_ready,
        output alu_a, alu_b, alu_funct3, alu_funct7, alu_opcode,
        output rsp_valid, rsp_id, rsp_tag, rsp_data
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_funct3, r0_funct7, r0_opcode, r0_tag,
        output r1_valid, r1_a, r1_b, r1_funct3, r1_funct7, r1_opcode, r1_tag,
        output alu_out, rsp_ready,
        input  r0_ready, r1_ready,
        input  alu_a, alu_b, alu_funct3, alu_funct7, alu_opcode,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared combinational ALU, one op in flight.
// Build option: define ALU_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;
    logic             grant0;
    logic             grant1;
    logic             open_win;
    logic             accept;

`ifdef ALU_ARB_RR_EN
    logic last;
    // Contention goes to whoever did not win last time; a lone requester always wins.
    assign grant0 = bus.r0_valid & (~bus.r1_valid | last);
    assign grant1 = bus.r1_valid & (~bus.r0_valid | ~last);
`else
    assign grant0 = bus.r0_valid;
    assign grant1 = bus.r1_valid & ~bus.r0_valid;
`endif

    // A new op may enter while idle, or in the same cycle the pending response is taken.
    assign open_win     = (state == IDLE) | ((state == RESP) & bus.rsp_ready);
    assign bus.r0_ready = grant0 & open_win;
    assign bus.r1_ready = grant1 & open_win;
    assign accept       = bus.r0_ready | bus.r1_ready;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_funct3 <= '0;
            bus.alu_funct7 <= '0;
            bus.alu_opcode <= '0;
            tag_q          <= '0;
            id_q           <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_tag    <= '0;
            bus.rsp_data   <= '0;
`ifdef ALU_ARB_RR_EN
            last           <= 1'b1;
`endif
        end else begin
            if (accept) begin
                bus.alu_a      <= grant1 ? bus.r1_a      : bus.r0_a;
                bus.alu_b      <= grant1 ? bus.r1_b      : bus.r0_b;
                bus.alu_funct3 <= grant1 ? bus.r1_funct3 : bus.r0_funct3;
                bus.alu_funct7 <= grant1 ? bus.r1_funct7 : bus.r0_funct7;
                bus.alu_opcode <= grant1 ? bus.r1_opcode : bus.r0_opcode;
                tag_q          <= grant1 ? bus.r1_tag    : bus.r0_tag;
                id_q           <= grant1;
`ifdef ALU_ARB_RR_EN
                last           <= grant1;
`endif
            end
            case (state)
                IDLE: begin
                    if (accept) state <= EXEC;
                end
                EXEC: begin
                    bus.rsp_data  <= bus.alu_out;
                    bus.rsp_tag   <= tag_q;
                    bus.rsp_id    <= id_q;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= accept ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter; honours ALU_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int TAG_W = 4;
    localparam int SB_W  = 1 + TAG_W + 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         cmp_cnt = 0;
    int         fail_cnt = 0;
    int         cyc = 0;
    logic [SB_W-1:0] exp_q[$];

    alu_arbiter_if #(.TAG_W(TAG_W)) bus();

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference RV32 integer ALU standing in for the shared ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [6:0] op);
        case (f3)
            3'd0: return (op == 7'h33 && f7[5]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return {31'b0, $signed(a) < $signed(b)};
            3'd3: return {31'b0, a < b};
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign bus.alu_out = alu_f(bus.alu_a, bus.alu_b, bus.alu_funct3, bus.alu_funct7, bus.alu_opcode);

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op,
                           input logic [TAG_W-1:0] tag);
        if (id == 0) begin
            bus.r0_valid = 1'b1; bus.r0_a = a; bus.r0_b = b; bus.r0_funct3 = f3;
            bus.r0_funct7 = f7; bus.r0_opcode = op; bus.r0_tag = tag;
        end else begin
            bus.r1_valid = 1'b1; bus.r1_a = a; bus.r1_b = b; bus.r1_funct3 = f3;
            bus.r1_funct7 = f7; bus.r1_opcode = op; bus.r1_tag = tag;
        end
    endtask

    task automatic rand_req(input int id);
        set_req(id, $urandom, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) ? 7'h20 : 7'h00,
                $urandom_range(0, 1) ? 7'h33 : 7'h13, TAG_W'($urandom_range(0, 15)));
    endtask

    task automatic clr_req(input int id);
        if (id == 0) bus.r0_valid = 1'b0;
        else         bus.r1_valid = 1'b0;
    endtask

    function automatic logic [SB_W-1:0] exp_of(input int id);
        if (id == 0)
            return {1'b0, bus.r0_tag, alu_f(bus.r0_a, bus.r0_b, bus.r0_funct3, bus.r0_funct7, bus.r0_opcode)};
        return {1'b1, bus.r1_tag, alu_f(bus.r1_a, bus.r1_b, bus.r1_funct3, bus.r1_funct7, bus.r1_opcode)};
    endfunction

    task automatic do_reset();
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Holds a request until it is taken; returns just after the accepting edge.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op,
                         input logic [TAG_W-1:0] tag);
        bit seen;
        bit ok;
        ok = 1'b0;
        set_req(id, a, b, f3, f7, op, tag);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            seen = (id == 0) ? bus.r0_ready : bus.r1_ready;
            @(posedge clk); #1;
            if (seen) ok = 1'b1;
        end
        clr_req(id);
        cmp_cnt++;
        if (!ok) begin
            fail_cnt++;
            $display("FAIL issue_timeout: requester %0d got no ready, required within 20 cycles", id);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        cmp_cnt++;
        if (state_dbg !== 2'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 ||
            bus.rsp_tag !== '0 || bus.rsp_data !== 32'd0) begin
            fail_cnt++;
            $display("FAIL reset_rsp: state %0d valid %b id %b tag %h data %h, required 0/0/0/0/0",
                     state_dbg, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data);
        end
        cmp_cnt++;
        if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_funct3 !== 3'd0 ||
            bus.alu_funct7 !== 7'd0 || bus.alu_opcode !== 7'd0) begin
            fail_cnt++;
            $display("FAIL reset_alu: a %h b %h f3 %h f7 %h op %h, required all 0",
                     bus.alu_a, bus.alu_b, bus.alu_funct3, bus.alu_funct7, bus.alu_opcode);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL idle_ready: r0_ready %b r1_ready %b rsp_valid %b, required 0/0/0",
                     bus.r0_ready, bus.r1_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bus.rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd7, 3'd0, 7'h00, 7'h33, 4'h9);
        @(negedge clk);
        cmp_cnt++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_ready: r0_ready %b r1_ready %b, required 1/0", bus.r0_ready, bus.r1_ready);
        end
        @(posedge clk); #1 clr_req(0);
        @(negedge clk);
        cmp_cnt++;
        if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_opcode !== 7'h33 || bus.rsp_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_exec: alu_a %h alu_b %h op %h rsp_valid %b, required 5/7/33/0",
                     bus.alu_a, bus.alu_b, bus.alu_opcode, bus.rsp_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_id !== 1'b0 || bus.rsp_tag !== 4'h9) begin
            fail_cnt++;
            $display("FAIL single_rsp: valid %b data %h id %b tag %h, required 1/0000000c/0/9",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_tag);
        end
        @(posedge clk); #1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.rsp_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_drop: rsp_valid %b after handshake, required 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_r1_ops();
        bus.rsp_ready = 1'b1;
        issue(1, 32'd10, 32'd3, 3'd0, 7'h20, 7'h33, 4'h3);
        @(posedge clk); #1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd7 || bus.rsp_id !== 1'b1 || bus.rsp_tag !== 4'h3) begin
            fail_cnt++;
            $display("FAIL r1_sub: valid %b data %h id %b tag %h, required 1/00000007/1/3",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_tag);
        end
        @(posedge clk); #1;
        issue(1, 32'h8000_0000, 32'd4, 3'd5, 7'h20, 7'h13, 4'hE);
        @(posedge clk); #1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hF800_0000 || bus.rsp_id !== 1'b1 || bus.rsp_tag !== 4'hE) begin
            fail_cnt++;
            $display("FAIL r1_srai: valid %b data %h id %b tag %h, required 1/f8000000/1/e",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_both_valid();
        logic ids[4];
        logic exp_ids[4];
        int   got;
        int   r1_acc;
        int   exp_r1_acc;
        bit   acc0;
        bit   acc1;
        logic [SB_W-1:0] e;
`ifdef ALU_ARB_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_r1_acc = 2;
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_r1_acc = 0;
`endif
        do_reset();
        bus.rsp_ready = 1'b1;
        got = 0;
        r1_acc = 0;
        rand_req(0);
        rand_req(1);
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            acc0 = bus.r0_valid & bus.r0_ready;
            acc1 = bus.r1_valid & bus.r1_ready;
            cmp_cnt++;
            if (acc0 && acc1) begin
                fail_cnt++;
                $display("FAIL both_onehot: r0_ready %b r1_ready %b, required one-hot", bus.r0_ready, bus.r1_ready);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                ids[got] = bus.rsp_id;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                cmp_cnt++;
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    fail_cnt++;
                    $display("FAIL both_rsp: got id %b tag %h data %h, required id %b tag %h data %h",
                             bus.rsp_id, bus.rsp_tag, bus.rsp_data, e[SB_W-1], e[SB_W-2:32], e[31:0]);
                end
                got++;
            end
            if (acc0) exp_q.push_back(exp_of(0));
            if (acc1) begin exp_q.push_back(exp_of(1)); r1_acc++; end
            @(posedge clk); #1;
            if (acc0) rand_req(0);
            if (acc1) rand_req(1);
        end
        clr_req(0);
        clr_req(1);
        cmp_cnt++;
        if (got != 4) begin
            fail_cnt++;
            $display("FAIL both_count: %0d responses in 40 cycles, required 4", got);
        end
        for (int i = 0; i < got; i++) begin
            cmp_cnt++;
            if (ids[i] !== exp_ids[i]) begin
                fail_cnt++;
                $display("FAIL both_order: response %0d id %b, required %b", i, ids[i], exp_ids[i]);
            end
        end
        cmp_cnt++;
        if (r1_acc != exp_r1_acc) begin
            fail_cnt++;
            $display("FAIL both_r1_accepts: %0d accepts of r1, required %0d", r1_acc, exp_r1_acc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        do_reset();
        exp_d0 = alu_f(32'h0000_1111, 32'h0000_0222, 3'd4, 7'h00, 7'h33);
        exp_d1 = alu_f(32'h0000_00F0, 32'h0000_000F, 3'd6, 7'h00, 7'h33);
        issue(0, 32'h0000_1111, 32'h0000_0222, 3'd4, 7'h00, 7'h33, 4'hA);
        set_req(1, 32'h0000_00F0, 32'h0000_000F, 3'd6, 7'h00, 7'h33, 4'h5);
        @(negedge clk);
        cmp_cnt++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL bp_exec_ready: r0_ready %b r1_ready %b while busy, required 0/0", bus.r0_ready, bus.r1_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d0 || bus.rsp_tag !== 4'hA || bus.rsp_id !== 1'b0) begin
                fail_cnt++;
                $display("FAIL bp_hold: stall %0d valid %b data %h tag %h id %b, required 1/%h/a/0",
                         i, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id, exp_d0);
            end
            cmp_cnt++;
            if (bus.r1_ready !== 1'b0) begin
                fail_cnt++;
                $display("FAIL bp_no_accept: stall %0d r1_ready %b, required 0", i, bus.r1_ready);
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.r1_ready !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL bp_release: r1_ready %b rsp_valid %b, required 1/1", bus.r1_ready, bus.rsp_valid);
        end
        @(posedge clk); #1 clr_req(1);
        @(negedge clk);
        cmp_cnt++;
        if (bus.rsp_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL bp_gap: rsp_valid %b one cycle after accept, required 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d1 || bus.rsp_id !== 1'b1 || bus.rsp_tag !== 4'h5) begin
            fail_cnt++;
            $display("FAIL bp_next: valid %b data %h id %b tag %h, required 1/%h/1/5",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_tag, exp_d1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b1;
        issue(0, 32'h0000_1234, 32'h0000_0001, 3'd0, 7'h00, 7'h33, 4'hC);
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (state_dbg !== 2'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 ||
            bus.rsp_tag !== '0 || bus.rsp_id !== 1'b0) begin
            fail_cnt++;
            $display("FAIL mid_reset_rsp: state %0d valid %b data %h tag %h id %b, required all 0",
                     state_dbg, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_id);
        end
        cmp_cnt++;
        if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_opcode !== 7'd0) begin
            fail_cnt++;
            $display("FAIL mid_reset_alu: a %h b %h op %h, required 0/0/0", bus.alu_a, bus.alu_b, bus.alu_opcode);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (bus.rsp_valid !== 1'b0) begin
                fail_cnt++;
                $display("FAIL mid_reset_stale: cycle %0d rsp_valid %b, required 0", i, bus.rsp_valid);
            end
            @(posedge clk); #1;
        end
        rand_req(0);
        rand_req(1);
        @(negedge clk);
        cmp_cnt++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL mid_reset_first_grant: r0_ready %b r1_ready %b, required 1/0", bus.r0_ready, bus.r1_ready);
        end
        @(posedge clk); #1;
        clr_req(0);
        clr_req(1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Randomised traffic against a rule-level model: one op in flight, response
    // valid from two cycles after its accept, contention settled by the policy.
    task automatic test_random();
        int   outstanding;
        int   acc_cyc;
        bit   model_last;
        bit   exp_rv;
        bit   exp_open;
        bit   v0;
        bit   v1;
        bit   pick;
        bit   exp_r0;
        bit   exp_r1;
        bit   acc;
        logic [SB_W-1:0] e;
        do_reset();
        outstanding = 0;
        acc_cyc = 0;
        model_last = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!bus.r0_valid && $urandom_range(0, 1)) rand_req(0);
            if (!bus.r1_valid && $urandom_range(0, 2) != 0) rand_req(1);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            v0 = bus.r0_valid;
            v1 = bus.r1_valid;
            exp_rv = (outstanding != 0) && (cyc - acc_cyc >= 2);
            exp_open = (outstanding == 0) || (exp_rv && bus.rsp_ready);
`ifdef ALU_ARB_RR_EN
            pick = (v0 && v1) ? ~model_last : ~v0;
`else
            pick = ~v0;
`endif
            exp_r0 = exp_open && v0 && !pick;
            exp_r1 = exp_open && v1 && pick;
            cmp_cnt++;
            if (bus.r0_ready !== exp_r0 || bus.r1_ready !== exp_r1) begin
                fail_cnt++;
                $display("FAIL rand_ready: cycle %0d r0_ready %b r1_ready %b, required %b/%b",
                         c, bus.r0_ready, bus.r1_ready, exp_r0, exp_r1);
            end
            cmp_cnt++;
            if (bus.rsp_valid !== exp_rv) begin
                fail_cnt++;
                $display("FAIL rand_rsp_valid: cycle %0d rsp_valid %b, required %b", c, bus.rsp_valid, exp_rv);
            end
            if (exp_rv && exp_q.size() > 0) begin
                e = exp_q[0];
                cmp_cnt++;
                if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== e) begin
                    fail_cnt++;
                    $display("FAIL rand_rsp: cycle %0d id %b tag %h data %h, required id %b tag %h data %h",
                             c, bus.rsp_id, bus.rsp_tag, bus.rsp_data, e[SB_W-1], e[SB_W-2:32], e[31:0]);
                end
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
            if (exp_rv && bus.rsp_ready) outstanding = 0;
            acc = exp_open && (v0 || v1);
            if (acc) begin
                exp_q.push_back(exp_of(pick ? 1 : 0));
                model_last = pick;
                outstanding = 1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
            if (acc) clr_req(pick ? 1 : 0);
        end
        clr_req(0);
        clr_req(1);
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_funct3 = '0;
        bus.r0_funct7 = '0; bus.r0_opcode = '0; bus.r0_tag = '0;
        bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_funct3 = '0;
        bus.r1_funct7 = '0; bus.r1_opcode = '0; bus.r1_tag = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_r1_ops();
        test_both_valid();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU in the RISC-V soft processor. Requesters are the execute stage (requester 0) and the branch/address-generation path (requester 1). The block accepts one operation at a time over a valid/ready handshake, drives registered operands and control fields into the ALU, and captures the ALU result. It returns the result with the requester id and tag on a single response channel that supports backpressure.

## Interface
- TAG_W, 4, width of the opaque per-request tag echoed on the response
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- r0_valid / r1_valid  in  1  request valid, per requester
- r0_ready / r1_ready  out  1  request accepted this cycle; combinational
- r0_a, r0_b / r1_a, r1_b  in  32  operands
- r0_funct3 / r1_funct3  in  3  ALU funct3
- r0_funct7 / r1_funct7  in  7  ALU funct7
- r0_opcode / r1_opcode  in  7  ALU opcode
- r0_tag / r1_tag  in  TAG_W  request tag
- alu_a, alu_b  out  32  registered operands to the ALU
- alu_funct3  out  3  registered funct3 to the ALU
- alu_funct7, alu_opcode  out  7  registered funct7 and opcode to the ALU
- alu_out  in  32  combinational ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_tag  out  TAG_W  echoed tag
- rsp_data  out  32  captured ALU result

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Accept window: `open = (state==IDLE) | (state==RESP & rsp_ready)`.
- Grant (combinational) is one-hot among valid requesters; `rX_ready = grant_X & open`. Ready is never high while the requester's valid is low.
- On accept (`rX_valid & rX_ready`):
  - latch a, b, funct3, funct7 and opcode into the alu_* registers;
  - latch the tag and the id;
  - go to EXEC.
- EXEC: `rsp_data <= alu_out`, rsp_tag/rsp_id take the latched values, go to RESP. The ALU decode is not interpreted; operands pass through unchanged.
- RESP: rsp_valid = 1. Response fields are held stable until `rsp_ready`.
  - rsp_ready with a new accept in the same cycle: go to EXEC.
  - rsp_ready with no accept: go to IDLE.
  - no rsp_ready: stay in RESP.
- rsp_valid = 1 only in RESP.
- At most one operation is in flight; a third request is never accepted.
- Boundary conditions:
  - Both requesters valid: the arbitration policy (see Configuration) picks one; the loser's ready is 0 and it must hold its request.
  - A requester dropping valid before ready is a protocol violation; the block needs no defined behaviour for it.
  - rsp_ready asserted outside RESP is ignored.
  - Reset mid-operation aborts the operation; no response is produced.
- Reset values: state IDLE; rsp_valid 0; rsp_id 0; rsp_tag 0; rsp_data 0; alu_a, alu_b, alu_funct3, alu_funct7, alu_opcode all 0; round-robin pointer `last` = 1. r0_ready and r1_ready are 0 while both valids are low.

## Timing
- Accept in cycle N. alu_* update at edge N. Result captured at edge N+1. rsp_valid is high from cycle N+2.
- Latency: 2 cycles from accept to response valid.
- Peak throughput: one operation per 2 cycles, with back-to-back accept in RESP while rsp_ready = 1.
- alu_out must settle within one cycle of the alu_* registers.
- Ready path: valid → grant → ready is combinational, with no register in between.

## Configuration
- Macro `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - `last` is updated to the granted id on each accept.
  - When both requesters are valid, grant goes to `~last`.
  - When a single requester is valid, it is granted regardless of `last`.
- Undefined: fixed priority; requester 0 always wins, and `last` is not implemented.

## Test plan
- Single r0 request a=5, b=7, funct3=0, funct7=0, opcode=0x33 → r0_ready in the accept cycle; rsp_valid 2 cycles later with rsp_data=12, rsp_id=0, echoed tag.
- r1 request a=10, b=3, funct7=0x20, funct3=0 → rsp_data=7, rsp_id=1. Then a=0x80000000, b=4, funct3=5, funct7=0x20, opcode=0x13 → rsp_data=0xF8000000.
- Both requesters held valid for 4 operations with rsp_ready=1:
  - with ALU_ARB_RR_EN, rsp_id sequence is 0, 1, 0, 1;
  - without it, the sequence is 0, 0, 0, 0 and r1_ready is never asserted.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_tag are stable and no request is accepted. rsp_ready=1 with a pending request → accept in the same cycle and the next response 2 cycles later.
- Reset asserted in EXEC → all outputs return to reset values asynchronously. After release, no stale response appears and the first grant goes to r0 in both configurations.
